pc_stack_unit: RTL

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pc_stack_unit.sv
// Program counter with relative/absolute branches and a LIFO return-address stack.
// Push/pop misuse is reported through sticky error flags.
module pc_stack_unit #(
  parameter int              WIDTH     = 16,
  parameter int              DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2:0]                 op,
  input  logic                       cond,
  input  logic signed [WIDTH-1:0]    offset,
  input  logic [WIDTH-1:0]           target,
  input  logic                       clrErr,
  output logic [WIDTH-1:0]           count,
  output logic [WIDTH-1:0]           topAddr,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       ovfErr,
  output logic                       unfErr
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_BREL = 3'b010;
  localparam logic [2:0] OP_BABS = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  logic [WIDTH-1:0] r_count;
  logic [LW-1:0]    r_level;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] r_stack [DEPTH];

  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_rel;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_top;
  logic [AW-1:0]    w_rd_idx;
  logic [AW-1:0]    w_wr_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_unf_set;

  always_comb begin
    w_inc    = r_count + 1'b1;
    w_rel    = $signed(r_count) + offset;
    w_full   = (r_level == LW'(DEPTH));
    w_empty  = (r_level == '0);
    w_rd_idx = AW'(r_level - LW'(1));
    w_wr_idx = r_level[AW-1:0];
    w_top    = w_empty ? '0 : r_stack[w_rd_idx];
  end

  always_comb begin
    w_next    = r_count;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (op)
      OP_INC:  w_next = w_inc;
      OP_BREL: w_next = cond ? w_rel : w_inc;
      OP_BABS: w_next = cond ? target : w_inc;
      OP_CALL: begin
        if (cond) begin
          w_next = target;
          // A full stack still takes the jump; only the return address is lost.
          if (w_full) w_ovf_set = 1'b1;
          else        w_push    = 1'b1;
        end else begin
          w_next = w_inc;
        end
      end
      OP_RET: begin
        if (w_empty) begin
          w_next    = w_inc;
          w_unf_set = 1'b1;
        end else begin
          w_next = w_top;
          w_pop  = 1'b1;
        end
      end
      default: w_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= RESET_VEC;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_next;
      if (w_push)     r_level <= r_level + 1'b1;
      else if (w_pop) r_level <= r_level - 1'b1;
      // A new error in the same cycle overrides the clear.
      r_ovf <= w_ovf_set | (r_ovf & ~clrErr);
      r_unf <= w_unf_set | (r_unf & ~clrErr);
    end
  end

  // Entries are never reset; level alone decides which ones are live.
  always_ff @(posedge clk) begin
    if (reset && w_push) r_stack[w_wr_idx] <= w_inc;
  end

  assign count   = r_count;
  assign topAddr = w_top;
  assign level   = r_level;
  assign full    = w_full;
  assign empty   = w_empty;
  assign ovfErr  = r_ovf;
  assign unfErr  = r_unf;

endmodule
